// File: rtl/pd_reset_pkg.sv
// ---------------------------------------------------------------------------
// pd_reset_pkg
// Shared types and constants for the Hard Reset / Cable Reset transmitter.
//   pd_state_e      : transmitter FSM states
//   TX_* constants  : TRANSMIT[2:0] codes and the idle SOP code
//   code_supported(): decides whether a TRANSMIT code is sent to the PHY
// Build option: PD_CABLE_RESET_EN (defined -> cable reset code accepted).
// ---------------------------------------------------------------------------
package pd_reset_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_GAP    = 2'd2,
        ST_REPORT = 2'd3
    } pd_state_e;

    localparam logic [2:0] TX_IDLE        = 3'b000;
    localparam logic [2:0] TX_HARD_RESET  = 3'b101;
    localparam logic [2:0] TX_CABLE_RESET = 3'b110;

    function automatic logic code_supported(input logic [2:0] code);
`ifdef PD_CABLE_RESET_EN
        return (code == TX_HARD_RESET) || (code == TX_CABLE_RESET);
`else
        return (code == TX_HARD_RESET);
`endif
    endfunction

endpackage

// File: rtl/pd_down_counter.sv
// ---------------------------------------------------------------------------
// pd_down_counter
// Loadable down-counter that saturates at 1 (never wraps, never reaches 0
// through counting). Used for the attempt timer and the inter-attempt gap.
// Ports:
//   clk_i, rst_n_i : clock, asynchronous active-low reset (count -> 0)
//   load_i         : load load_val_i (has priority over en_i)
//   load_val_i     : value to load
//   en_i           : decrement by one while count > 1
//   count_o        : current count
//   is_one_o       : count == 1 (terminal count)
// ---------------------------------------------------------------------------
module pd_down_counter #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic [W-1:0] count_o,
    output logic         is_one_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (en_i && (count_q > W'(1))) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o  = count_q;
    assign is_one_o = (count_q == W'(1));

endmodule

// File: rtl/pd_reset_signal_tx.sv
// ---------------------------------------------------------------------------
// pd_reset_signal_tx
// Hard Reset / Cable Reset signalling transmitter. Decodes TRANSMIT[2:0],
// holds phy_request for each attempt, retries on timeout with an idle gap,
// and reports one ALERT pulse (success or failed) per accepted tx_start.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// ST_IDLE   | waiting for tx_start
// ST_REQ    | phy_request high, attempt timer running
// ST_GAP    | idle gap between attempts, phy_request low
// ST_REPORT | one cycle, result alert being reported
//
// Ports:
//   clk, reset_L            : clock, asynchronous active-low reset
//   tx_start, TRANSMIT      : start pulse and TCPC TRANSMIT register
//   timeout_cycles          : attempt length, sampled at tx_start (0 -> 1)
//   phy_response            : PHY ack, honoured only in ST_REQ
//   phy_request, phy_sop_type : PHY request and code being sent
//   busy, retry_count, req_dropped : status
//   ALERT_TransmitSuccessful, ALERT_TransmitSOPMessageFailed : result pulses
// Build option: PD_CABLE_RESET_EN (see pd_reset_pkg::code_supported).
// ---------------------------------------------------------------------------
module pd_reset_signal_tx
    import pd_reset_pkg::*;
#(
    parameter  int TIMER_W     = 32,
    parameter  int MAX_RETRIES = 2,
    parameter  int GAP_CYCLES  = 4,
    localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1,
    localparam int GW = $clog2(GAP_CYCLES + 1)
) (
    input  logic               clk,
    input  logic               reset_L,
    input  logic               tx_start,
    input  logic [7:0]         TRANSMIT,
    input  logic [TIMER_W-1:0] timeout_cycles,
    input  logic               phy_response,
    output logic               phy_request,
    output logic [2:0]         phy_sop_type,
    output logic               busy,
    output logic [RW-1:0]      retry_count,
    output logic               req_dropped,
    output logic               ALERT_TransmitSuccessful,
    output logic               ALERT_TransmitSOPMessageFailed
);

    pd_state_e          state_q, state_d;
    logic [2:0]         code_q, code_d;
    logic [TIMER_W-1:0] timeout_q, timeout_d;
    logic [RW-1:0]      retry_q, retry_d;
    // Unsupported code: REPORT is entered without an alert; the failed
    // alert is emitted as REPORT exits, giving the N+2 failure timing.
    logic               pend_q, pend_d;
    logic               phy_request_q, phy_request_d;
    logic [2:0]         sop_q, sop_d;
    logic               busy_q, busy_d;
    logic               dropped_q, dropped_d;
    logic               succ_q, succ_d;
    logic               fail_q, fail_d;

    logic               tmr_load, tmr_en, tmr_is_one;
    logic [TIMER_W-1:0] tmr_load_val;
    logic [TIMER_W-1:0] tmr_count_unused;
    logic               gap_load, gap_en, gap_is_one;
    logic [GW-1:0]      gap_count_unused;
    logic [TIMER_W-1:0] timeout_eff;
    logic               unused_transmit_hi;

    assign unused_transmit_hi = ^TRANSMIT[7:3];
    assign timeout_eff = (timeout_cycles == '0) ? TIMER_W'(1) : timeout_cycles;

    pd_down_counter #(.W(TIMER_W)) u_attempt_timer (
        .clk_i      (clk),
        .rst_n_i    (reset_L),
        .load_i     (tmr_load),
        .load_val_i (tmr_load_val),
        .en_i       (tmr_en),
        .count_o    (tmr_count_unused),
        .is_one_o   (tmr_is_one)
    );

    pd_down_counter #(.W(GW)) u_gap_timer (
        .clk_i      (clk),
        .rst_n_i    (reset_L),
        .load_i     (gap_load),
        .load_val_i (GW'(GAP_CYCLES)),
        .en_i       (gap_en),
        .count_o    (gap_count_unused),
        .is_one_o   (gap_is_one)
    );

    always_comb begin
        state_d      = state_q;
        code_d       = code_q;
        timeout_d    = timeout_q;
        retry_d      = retry_q;
        pend_d       = pend_q;
        dropped_d    = 1'b0;
        succ_d       = 1'b0;
        fail_d       = 1'b0;
        tmr_load     = 1'b0;
        tmr_load_val = timeout_q;
        tmr_en       = 1'b0;
        gap_load     = 1'b0;
        gap_en       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (tx_start) begin
                    retry_d = '0;
                    if (code_supported(TRANSMIT[2:0])) begin
                        state_d      = ST_REQ;
                        code_d       = TRANSMIT[2:0];
                        timeout_d    = timeout_eff;
                        tmr_load     = 1'b1;
                        tmr_load_val = timeout_eff;
                    end else begin
                        state_d = ST_REPORT;
                        code_d  = TX_IDLE;
                        pend_d  = 1'b1;
                    end
                end
            end
            ST_REQ: begin
                // Ack has priority over an expiring timer in the same cycle.
                if (phy_response) begin
                    state_d = ST_REPORT;
                    succ_d  = 1'b1;
                end else if (tmr_is_one) begin
                    if (retry_q < RW'(MAX_RETRIES)) begin
                        state_d  = ST_GAP;
                        retry_d  = retry_q + RW'(1);
                        gap_load = 1'b1;
                    end else begin
                        state_d = ST_REPORT;
                        fail_d  = 1'b1;
                    end
                end else begin
                    tmr_en = 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_is_one) begin
                    state_d  = ST_REQ;
                    tmr_load = 1'b1;
                end else begin
                    gap_en = 1'b1;
                end
            end
            ST_REPORT: begin
                state_d = ST_IDLE;
                fail_d  = pend_q;
                pend_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (tx_start && (state_q != ST_IDLE)) begin
            dropped_d = 1'b1;
        end

        phy_request_d = (state_d == ST_REQ);
        sop_d         = (state_d == ST_REQ) ? code_d : TX_IDLE;
        busy_d        = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q       <= ST_IDLE;
            code_q        <= TX_IDLE;
            timeout_q     <= '0;
            retry_q       <= '0;
            pend_q        <= 1'b0;
            phy_request_q <= 1'b0;
            sop_q         <= TX_IDLE;
            busy_q        <= 1'b0;
            dropped_q     <= 1'b0;
            succ_q        <= 1'b0;
            fail_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            code_q        <= code_d;
            timeout_q     <= timeout_d;
            retry_q       <= retry_d;
            pend_q        <= pend_d;
            phy_request_q <= phy_request_d;
            sop_q         <= sop_d;
            busy_q        <= busy_d;
            dropped_q     <= dropped_d;
            succ_q        <= succ_d;
            fail_q        <= fail_d;
        end
    end

    assign phy_request                    = phy_request_q;
    assign phy_sop_type                   = sop_q;
    assign busy                           = busy_q;
    assign retry_count                    = retry_q;
    assign req_dropped                    = dropped_q;
    assign ALERT_TransmitSuccessful       = succ_q;
    assign ALERT_TransmitSOPMessageFailed = fail_q;

endmodule

// File: tb/tb_pd_reset_signal_tx.sv
module tb_pd_reset_signal_tx;
    import pd_reset_pkg::*;

    localparam int MAX_RETRIES = 2;
    localparam int GAP_CYCLES  = 4;

    logic        clk = 1'b0;
    logic        reset_L = 1'b0;
    logic        tx_start = 1'b0;
    logic [7:0]  TRANSMIT = 8'h00;
    logic [31:0] timeout_cycles = 32'd0;
    logic        phy_response = 1'b0;
    logic        phy_request;
    logic [2:0]  phy_sop_type;
    logic        busy;
    logic [1:0]  retry_count;
    logic        req_dropped;
    logic        succ;
    logic        fail;

    pd_reset_signal_tx #(.TIMER_W(32), .MAX_RETRIES(MAX_RETRIES), .GAP_CYCLES(GAP_CYCLES)) dut (
        .clk                            (clk),
        .reset_L                        (reset_L),
        .tx_start                       (tx_start),
        .TRANSMIT                       (TRANSMIT),
        .timeout_cycles                 (timeout_cycles),
        .phy_response                   (phy_response),
        .phy_request                    (phy_request),
        .phy_sop_type                   (phy_sop_type),
        .busy                           (busy),
        .retry_count                    (retry_count),
        .req_dropped                    (req_dropped),
        .ALERT_TransmitSuccessful       (succ),
        .ALERT_TransmitSOPMessageFailed (fail)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        bit ok;
        int retry;
    } exp_t;

    exp_t sb_q[$];
    int   win_q[$];
    int   gap_q[$];
    int   alert_cnt;
    int   dropped_cnt;

    // Per-run observations filled by observe()
    int         o_req_total, o_first_req, o_alert_idx, o_drop_idx;
    logic [2:0] o_sop;
    logic       o_busy_first, o_busy_after;

    function automatic exp_t mk(input bit ok, input int retry);
        exp_t e;
        e.ok = ok;
        e.retry = retry;
        return e;
    endfunction

    task automatic start_tx(input logic [7:0] tr, input logic [31:0] to);
        @(negedge clk);
        TRANSMIT = tr;
        timeout_cycles = to;
        tx_start = 1'b1;
    endtask

    // Sample index i counts negedges after the edge that sampled tx_start.
    task automatic observe(input int ack_at, input bit ack_in_gap, input int drop_at, input int budget);
        int   cur_win = 0;
        int   cur_gap = 0;
        exp_t e;
        o_req_total = 0; o_first_req = -1; o_alert_idx = -1; o_drop_idx = -1;
        o_sop = 3'b000; o_busy_first = 1'b0; o_busy_after = 1'b1;
        win_q.delete(); gap_q.delete(); alert_cnt = 0; dropped_cnt = 0;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (i == 1) o_busy_first = busy;
            if (phy_request) begin
                if (cur_gap > 0) begin gap_q.push_back(cur_gap); cur_gap = 0; end
                if (o_first_req < 0) begin o_first_req = i; o_sop = phy_sop_type; end
                o_req_total++;
                cur_win++;
            end else begin
                if (cur_win > 0) begin win_q.push_back(cur_win); cur_win = 0; end
                if (o_req_total > 0 && busy && !succ && !fail) cur_gap++;
            end
            if (req_dropped) begin
                dropped_cnt++;
                if (o_drop_idx < 0) o_drop_idx = i;
            end
            if (o_alert_idx > 0 && i == o_alert_idx + 1) o_busy_after = busy;
            if (succ || fail) begin
                alert_cnt++;
                if (o_alert_idx < 0) o_alert_idx = i;
                tests_run++;
                if (sb_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL sb_unexpected_alert: got succ=%0b fail=%0b, expected no alert", succ, fail);
                end else begin
                    e = sb_q.pop_front();
                    if ({succ, fail} !== {e.ok, !e.ok} || retry_count !== 2'(e.retry)) begin
                        tests_failed++;
                        $display("FAIL sb_result: got succ=%0b fail=%0b retry=%0d, expected succ=%0b fail=%0b retry=%0d",
                                 succ, fail, retry_count, e.ok, !e.ok, e.retry);
                    end
                end
            end
            phy_response = (ack_at > 0 && phy_request && o_req_total == ack_at) ||
                           (ack_in_gap && !phy_request && busy && o_req_total > 0);
            tx_start = (drop_at > 0 && i == drop_at);
            if (o_alert_idx > 0 && i >= o_alert_idx + 2) break;
        end
        phy_response = 1'b0;
        tx_start = 1'b0;
        if (cur_win > 0) win_q.push_back(cur_win);
        if (o_alert_idx < 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL observe_timeout: no alert within %0d cycles, expected one", budget);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        tests_run++;
        if ({phy_request, phy_sop_type, busy, retry_count, req_dropped, succ, fail} !== 10'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %b, expected all zero",
                     {phy_request, phy_sop_type, busy, retry_count, req_dropped, succ, fail});
        end
        reset_L = 1'b1;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({phy_request, busy, succ, fail} !== 4'd0) begin
            tests_failed++;
            $display("FAIL reset_release_idle: got %b, expected 0000", {phy_request, busy, succ, fail});
        end
    endtask

    task automatic test_success();
        sb_q.push_back(mk(1'b1, 0));
        start_tx(8'h05, 32'd10);
        observe(3, 1'b0, 0, 60);
        tests_run++;
        if (o_first_req !== 1 || o_busy_first !== 1'b1) begin
            tests_failed++;
            $display("FAIL success_latency: got first_req=%0d busy=%0b, expected 1 and 1", o_first_req, o_busy_first);
        end
        tests_run++;
        if (o_sop !== TX_HARD_RESET) begin
            tests_failed++;
            $display("FAIL success_sop: got %b, expected %b", o_sop, TX_HARD_RESET);
        end
        tests_run++;
        if (o_req_total !== 3 || win_q.size() !== 1 || o_alert_idx !== 4 || alert_cnt !== 1) begin
            tests_failed++;
            $display("FAIL success_window: got req=%0d wins=%0d alert_at=%0d alerts=%0d, expected 3 1 4 1",
                     o_req_total, win_q.size(), o_alert_idx, alert_cnt);
        end
        tests_run++;
        if (o_busy_after !== 1'b0) begin
            tests_failed++;
            $display("FAIL success_busy_drop: got busy=%0b after report, expected 0", o_busy_after);
        end
    endtask

    task automatic test_retry();
        int to = 5;
        sb_q.push_back(mk(1'b0, MAX_RETRIES));
        start_tx(8'h05, 32'(to));
        observe(0, 1'b0, 0, 100);
        tests_run++;
        if (win_q.size() !== MAX_RETRIES + 1 || gap_q.size() !== MAX_RETRIES) begin
            tests_failed++;
            $display("FAIL retry_counts: got wins=%0d gaps=%0d, expected %0d %0d",
                     win_q.size(), gap_q.size(), MAX_RETRIES + 1, MAX_RETRIES);
        end else begin
            foreach (win_q[k]) begin
                tests_run++;
                if (win_q[k] !== to) begin
                    tests_failed++;
                    $display("FAIL retry_window: window %0d got %0d, expected %0d", k, win_q[k], to);
                end
            end
            foreach (gap_q[k]) begin
                tests_run++;
                if (gap_q[k] !== GAP_CYCLES) begin
                    tests_failed++;
                    $display("FAIL retry_gap: gap %0d got %0d, expected %0d", k, gap_q[k], GAP_CYCLES);
                end
            end
        end
        tests_run++;
        if (o_alert_idx !== (MAX_RETRIES + 1) * to + MAX_RETRIES * GAP_CYCLES + 1 || alert_cnt !== 1) begin
            tests_failed++;
            $display("FAIL retry_alert: got at=%0d count=%0d, expected %0d 1", o_alert_idx, alert_cnt,
                     (MAX_RETRIES + 1) * to + MAX_RETRIES * GAP_CYCLES + 1);
        end
    endtask

    task automatic test_ack_boundary();
        sb_q.push_back(mk(1'b1, 0));
        start_tx(8'h05, 32'd4);
        observe(4, 1'b0, 0, 60);
        tests_run++;
        if (o_req_total !== 4 || win_q.size() !== 1 || o_alert_idx !== 5) begin
            tests_failed++;
            $display("FAIL ack_at_timer_one: got req=%0d wins=%0d alert_at=%0d, expected 4 1 5",
                     o_req_total, win_q.size(), o_alert_idx);
        end
        sb_q.push_back(mk(1'b0, MAX_RETRIES));
        start_tx(8'h05, 32'd2);
        observe(0, 1'b1, 0, 80);
        tests_run++;
        if (win_q.size() !== MAX_RETRIES + 1 || o_req_total !== 2 * (MAX_RETRIES + 1) ||
            o_alert_idx !== 2 * (MAX_RETRIES + 1) + GAP_CYCLES * MAX_RETRIES + 1) begin
            tests_failed++;
            $display("FAIL ack_in_gap_ignored: got wins=%0d req=%0d alert_at=%0d, expected %0d %0d %0d",
                     win_q.size(), o_req_total, o_alert_idx, MAX_RETRIES + 1, 2 * (MAX_RETRIES + 1),
                     2 * (MAX_RETRIES + 1) + GAP_CYCLES * MAX_RETRIES + 1);
        end
    endtask

    task automatic test_codes();
`ifdef PD_CABLE_RESET_EN
        sb_q.push_back(mk(1'b1, 0));
        start_tx(8'h06, 32'd8);
        observe(2, 1'b0, 0, 60);
        tests_run++;
        if (o_sop !== TX_CABLE_RESET || o_req_total !== 2 || o_alert_idx !== 3) begin
            tests_failed++;
            $display("FAIL cable_reset_sent: got sop=%b req=%0d alert_at=%0d, expected 110 2 3",
                     o_sop, o_req_total, o_alert_idx);
        end
`else
        sb_q.push_back(mk(1'b0, 0));
        start_tx(8'h06, 32'd8);
        observe(0, 1'b0, 0, 20);
        tests_run++;
        if (o_first_req !== -1 || o_alert_idx !== 2 || o_busy_first !== 1'b1) begin
            tests_failed++;
            $display("FAIL cable_reset_rejected: got first_req=%0d alert_at=%0d busy=%0b, expected -1 2 1",
                     o_first_req, o_alert_idx, o_busy_first);
        end
`endif
        sb_q.push_back(mk(1'b0, 0));
        start_tx(8'h03, 32'd8);
        observe(0, 1'b0, 0, 20);
        tests_run++;
        if (o_first_req !== -1 || o_alert_idx !== 2 || alert_cnt !== 1) begin
            tests_failed++;
            $display("FAIL unsupported_code: got first_req=%0d alert_at=%0d alerts=%0d, expected -1 2 1",
                     o_first_req, o_alert_idx, alert_cnt);
        end
        sb_q.push_back(mk(1'b1, 0));
        start_tx(8'hFD, 32'd8);
        observe(1, 1'b0, 0, 20);
        tests_run++;
        if (o_sop !== TX_HARD_RESET || o_alert_idx !== 2) begin
            tests_failed++;
            $display("FAIL upper_bits_ignored: got sop=%b alert_at=%0d, expected 101 2", o_sop, o_alert_idx);
        end
    endtask

    task automatic test_dropped_and_zero_timeout();
        sb_q.push_back(mk(1'b1, 0));
        TRANSMIT = 8'h05;
        start_tx(8'h05, 32'd6);
        observe(5, 1'b0, 2, 60);
        tests_run++;
        if (o_drop_idx !== 3 || dropped_cnt !== 1 || o_req_total !== 5 || win_q.size() !== 1 || o_alert_idx !== 6) begin
            tests_failed++;
            $display("FAIL drop_while_busy: got drop_at=%0d drops=%0d req=%0d wins=%0d alert_at=%0d, expected 3 1 5 1 6",
                     o_drop_idx, dropped_cnt, o_req_total, win_q.size(), o_alert_idx);
        end
        sb_q.push_back(mk(1'b0, MAX_RETRIES));
        start_tx(8'h05, 32'd0);
        observe(0, 1'b0, 0, 60);
        tests_run++;
        if (win_q.size() !== MAX_RETRIES + 1 || o_req_total !== MAX_RETRIES + 1 ||
            o_alert_idx !== (MAX_RETRIES + 1) + GAP_CYCLES * MAX_RETRIES + 1) begin
            tests_failed++;
            $display("FAIL zero_timeout: got wins=%0d req=%0d alert_at=%0d, expected %0d %0d %0d",
                     win_q.size(), o_req_total, o_alert_idx, MAX_RETRIES + 1, MAX_RETRIES + 1,
                     (MAX_RETRIES + 1) + GAP_CYCLES * MAX_RETRIES + 1);
        end
    endtask

    task automatic test_reset_mid();
        int spurious = 0;
        start_tx(8'h05, 32'd10);
        @(negedge clk);
        tx_start = 1'b0;
        @(negedge clk);
        tests_run++;
        if (phy_request !== 1'b1) begin
            tests_failed++;
            $display("FAIL midreset_precondition: got phy_request=%0b, expected 1", phy_request);
        end
        #2 reset_L = 1'b0;
        #1;
        tests_run++;
        if ({phy_request, phy_sop_type, busy, retry_count, req_dropped, succ, fail} !== 10'd0) begin
            tests_failed++;
            $display("FAIL midreset_async_clear: got %b, expected all zero",
                     {phy_request, phy_sop_type, busy, retry_count, req_dropped, succ, fail});
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (succ || fail) spurious++;
        end
        reset_L = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (succ || fail || busy) spurious++;
        end
        tests_run++;
        if (spurious !== 0) begin
            tests_failed++;
            $display("FAIL midreset_no_alert: got %0d alert/busy samples, expected 0", spurious);
        end
        sb_q.push_back(mk(1'b1, 0));
        start_tx(8'h05, 32'd3);
        observe(1, 1'b0, 0, 30);
        tests_run++;
        if (o_first_req !== 1 || o_sop !== TX_HARD_RESET || o_alert_idx !== 2) begin
            tests_failed++;
            $display("FAIL midreset_recover: got first_req=%0d sop=%b alert_at=%0d, expected 1 101 2",
                     o_first_req, o_sop, o_alert_idx);
        end
    endtask

    initial begin
        test_reset();
        test_success();
        test_retry();
        test_ack_boundary();
        test_codes();
        test_dropped_and_zero_timeout();
        test_reset_mid();
        tests_run++;
        if (sb_q.size() !== 0) begin
            tests_failed++;
            $display("FAIL sb_leftover: got %0d pending results, expected 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
